// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encoding and constants for the radix-2 divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_ITERS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div32_radix2.sv
`default_nettype none
// ============================================================================
// Module   : div32_radix2
// Brief    : Fixed-latency radix-2 restoring divider, RISC-V DIV/DIVU/REM/REMU.
// Revision : 1.0
// ============================================================================
module div32_radix2
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             div_signed_i,
    output logic             out_en_o,
    output logic             idle_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam logic [5:0]       c_LAST    = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    div_state_t       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;       // dividend shifts out of the top, quotient bits enter at the bottom
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             out_en_q, out_en_d;
    logic             idle_q, idle_d;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dq_d     = dq_q;
        r_d      = r_q;
        dmag_d   = dmag_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        q_d      = q_q;
        rem_d    = rem_q;

        // Partial remainder can reach 2*divisor-1, so the compare needs one extra bit.
        w_trial  = {r_q, dq_q[WIDTH-1]};
        w_sub    = w_trial - {1'b0, dmag_q};
        w_ge     = (w_trial >= {1'b0, dmag_q});

        case (state_q)
            IDLE, DONE: begin
                if (in_en_i) begin
                    state_d = ITER;
                    cnt_d   = '0;
                    r_d     = '0;
                    dq_d    = f_mag(a_i, div_signed_i);
                    dmag_d  = f_mag(b_i, div_signed_i);
                    negq_d  = div_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    negr_d  = div_signed_i & a_i[WIDTH-1];
                    dz_d    = (b_i == '0);
                    ovf_d   = div_signed_i && (a_i == c_INT_MIN) && (b_i == '1);
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                r_d   = w_ge ? w_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
                dq_d  = {dq_q[WIDTH-2:0], w_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == c_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (dz_q) begin
                    q_d = '1;
                end else if (ovf_q) begin
                    q_d = c_INT_MIN;
                end else begin
                    q_d = negq_q ? -dq_q : dq_q;
                end
                // With a zero divisor the iterations leave |a| in r, so the sign fix restores a.
                rem_d = ovf_q ? '0 : (negr_q ? -r_q : r_q);
            end
            default: state_d = IDLE;
        endcase

        idle_d   = (state_d == IDLE) || (state_d == DONE);
        out_en_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dq_q     <= '0;
            r_q      <= '0;
            dmag_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            q_q      <= '0;
            rem_q    <= '0;
            out_en_q <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dq_q     <= dq_d;
            r_q      <= r_d;
            dmag_q   <= dmag_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            out_en_q <= out_en_d;
            idle_q   <= idle_d;
        end
    end

    assign out_en_o = out_en_q;
    assign idle_o   = idle_q;
    assign q_o      = q_q;
    assign rem_o    = rem_q;

endmodule : div32_radix2
`default_nettype wire

// File: tb/tb_div32_radix2.sv
`default_nettype none
// ============================================================================
// Module   : tb_div32_radix2
// Brief    : Directed self-checking bench for div32_radix2.
// Revision : 1.0
// ============================================================================
module tb_div32_radix2;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_en;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_signed;
    logic        out_en;
    logic        idle;
    logic [31:0] q;
    logic [31:0] rem;

    int errors = 0;
    int checks = 0;

    div32_radix2 #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_en_i      (in_en),
        .a_i          (a),
        .b_i          (b),
        .div_signed_i (div_signed),
        .out_en_o     (out_en),
        .idle_o       (idle),
        .q_o          (q),
        .rem_o        (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at cycle 0 (just after an edge); leaves the bench at cycle 34.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input int p1, input int p2,
                         output int done_cyc, output int n_out, output int idle_bad,
                         output logic [31:0] qo, output logic [31:0] ro);
        a = ta; b = tb_v; div_signed = ts; in_en = 1'b1;
        done_cyc = -1; n_out = 0; idle_bad = 0; qo = '0; ro = '0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            in_en = 1'b0;
            if (c == p1 || c == p2) begin
                in_en = 1'b1; a = 32'd1; b = 32'd1; div_signed = 1'b0;
            end
            if (out_en) begin
                n_out++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c < 34 && idle) idle_bad++;
            if (c == 34 && !idle) idle_bad++;
            if (c == 34) begin qo = q; ro = rem; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_en = 1'b0; a = '0; b = '0; div_signed = 1'b0;
        @(posedge clk); #1;
        checks++; if (idle !== 1'b1)  begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got=%b exp=0", out_en); end
        checks++; if (q !== 32'd0)     begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
        checks++; if (rem !== 32'd0)   begin errors++; $display("FAIL reset_rem got=%h exp=0", rem); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (idle !== 1'b1)  begin errors++; $display("FAIL post_reset_idle got=%b exp=1", idle); end
    endtask

    task automatic test_unsigned();
        int d, n, ib; logic [31:0] qo, ro;
        do_op(32'd100, 32'd7, 1'b0, -1, -1, d, n, ib, qo, ro);
        checks++; if (d !== 34)  begin errors++; $display("FAIL udiv_latency got=%0d exp=34", d); end
        checks++; if (n !== 1)   begin errors++; $display("FAIL udiv_pulses got=%0d exp=1", n); end
        checks++; if (ib !== 0)  begin errors++; $display("FAIL udiv_idle_bad got=%0d exp=0", ib); end
        checks++; if (qo !== 32'd14) begin errors++; $display("FAIL udiv_q got=%h exp=%h", qo, 32'd14); end
        checks++; if (ro !== 32'd2)  begin errors++; $display("FAIL udiv_rem got=%h exp=%h", ro, 32'd2); end
    endtask

    task automatic test_signed();
        int d, n, ib; logic [31:0] qo, ro;
        @(posedge clk); #1;
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1, d, n, ib, qo, ro);
        checks++; if (qo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2_q got=%h exp=FFFFFFFD", qo); end
        checks++; if (ro !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_2_rem got=%h exp=FFFFFFFF", ro); end
        @(posedge clk); #1;
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1, d, n, ib, qo, ro);
        checks++; if (qo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_7_m2_q got=%h exp=FFFFFFFD", qo); end
        checks++; if (ro !== 32'd1)         begin errors++; $display("FAIL sdiv_7_m2_rem got=%h exp=1", ro); end
        @(posedge clk); #1;
        do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, -1, -1, d, n, ib, qo, ro);
        checks++; if (qo !== 32'd3)         begin errors++; $display("FAIL sdiv_m7_m2_q got=%h exp=3", qo); end
        checks++; if (ro !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_m2_rem got=%h exp=FFFFFFFF", ro); end
    endtask

    task automatic test_div_zero();
        int d, n, ib; logic [31:0] qo, ro;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            do_op(32'd5, 32'd0, s[0], -1, -1, d, n, ib, qo, ro);
            checks++; if (d !== 34) begin errors++; $display("FAIL dz_latency s=%0d got=%0d exp=34", s, d); end
            checks++; if (qo !== DIV_ZERO_Q) begin errors++; $display("FAIL dz_q s=%0d got=%h exp=%h", s, qo, DIV_ZERO_Q); end
            checks++; if (ro !== 32'd5) begin errors++; $display("FAIL dz_rem s=%0d got=%h exp=5", s, ro); end
        end
        @(posedge clk); #1;
        do_op(32'hFFFF_FFFB, 32'd0, 1'b1, -1, -1, d, n, ib, qo, ro);
        checks++; if (qo !== DIV_ZERO_Q)    begin errors++; $display("FAIL dz_neg_q got=%h exp=%h", qo, DIV_ZERO_Q); end
        checks++; if (ro !== 32'hFFFF_FFFB) begin errors++; $display("FAIL dz_neg_rem got=%h exp=FFFFFFFB", ro); end
    endtask

    task automatic test_overflow();
        int d, n, ib; logic [31:0] qo, ro;
        @(posedge clk); #1;
        do_op(INT_MIN, 32'hFFFF_FFFF, 1'b1, -1, -1, d, n, ib, qo, ro);
        checks++; if (qo !== INT_MIN) begin errors++; $display("FAIL ovf_s_q got=%h exp=%h", qo, INT_MIN); end
        checks++; if (ro !== 32'd0)   begin errors++; $display("FAIL ovf_s_rem got=%h exp=0", ro); end
        @(posedge clk); #1;
        do_op(INT_MIN, 32'hFFFF_FFFF, 1'b0, -1, -1, d, n, ib, qo, ro);
        checks++; if (qo !== 32'd0)   begin errors++; $display("FAIL ovf_u_q got=%h exp=0", qo); end
        checks++; if (ro !== INT_MIN) begin errors++; $display("FAIL ovf_u_rem got=%h exp=%h", ro, INT_MIN); end
    endtask

    // Ends at cycle 34 so the back-to-back test can issue immediately.
    task automatic test_busy();
        int d, n, ib; logic [31:0] qo, ro;
        @(posedge clk); #1;
        do_op(32'd1000, 32'd10, 1'b0, 5, 20, d, n, ib, qo, ro);
        checks++; if (d !== 34)  begin errors++; $display("FAIL busy_latency got=%0d exp=34", d); end
        checks++; if (n !== 1)   begin errors++; $display("FAIL busy_pulses got=%0d exp=1", n); end
        checks++; if (ib !== 0)  begin errors++; $display("FAIL busy_idle_bad got=%0d exp=0", ib); end
        checks++; if (qo !== 32'd100) begin errors++; $display("FAIL busy_q got=%h exp=%h", qo, 32'd100); end
        checks++; if (ro !== 32'd0)   begin errors++; $display("FAIL busy_rem got=%h exp=0", ro); end
    endtask

    task automatic test_back_to_back();
        int d, n, ib; logic [31:0] qo, ro;
        do_op(32'd9, 32'd4, 1'b0, -1, -1, d, n, ib, qo, ro);
        checks++; if (d !== 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", d); end
        checks++; if (n !== 1)  begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", n); end
        checks++; if (ib !== 0) begin errors++; $display("FAIL b2b_idle_bad got=%0d exp=0", ib); end
        checks++; if (qo !== 32'd2) begin errors++; $display("FAIL b2b_q got=%h exp=2", qo); end
        checks++; if (ro !== 32'd1) begin errors++; $display("FAIL b2b_rem got=%h exp=1", ro); end
    endtask

    task automatic test_reset_mid();
        int d, n, ib, stray; logic [31:0] qo, ro;
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd3; div_signed = 1'b0; in_en = 1'b1;
        stray = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            in_en = 1'b0;
            if (c == 10) begin
                rst = 1'b1;
                #1;
                checks++; if (idle !== 1'b1)  begin errors++; $display("FAIL midrst_idle got=%b exp=1", idle); end
                checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL midrst_out_en got=%b exp=0", out_en); end
                checks++; if (q !== 32'd0)     begin errors++; $display("FAIL midrst_q got=%h exp=0", q); end
                checks++; if (rem !== 32'd0)   begin errors++; $display("FAIL midrst_rem got=%h exp=0", rem); end
            end
            if (c == 11) rst = 1'b0;
            if (out_en) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_stray_out got=%0d exp=0", stray); end
        do_op(32'd100, 32'd7, 1'b0, -1, -1, d, n, ib, qo, ro);
        checks++; if (d !== 34)      begin errors++; $display("FAIL midrst_new_latency got=%0d exp=34", d); end
        checks++; if (qo !== 32'd14) begin errors++; $display("FAIL midrst_new_q got=%h exp=%h", qo, 32'd14); end
        checks++; if (ro !== 32'd2)  begin errors++; $display("FAIL midrst_new_rem got=%h exp=2", ro); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div32_radix2
`default_nettype wire
